// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one external memory port between the instruction
//                fetch requester and the data requester. Data has fixed
//                priority, with a starvation guard for fetch. Responses are
//                routed back in order through an owner FIFO, and wrong-path
//                fetch responses are discarded after a pipeline flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_OUT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   // instruction fetch requester
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   output logic                    if_gnt_o,
   output logic                    if_rvalid_o,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   // data requester
   input  logic                    dm_req_i,
   input  logic                    dm_we_i,
   input  logic [DATA_WIDTH/8-1:0] dm_be_i,
   input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
   input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
   output logic                    dm_gnt_o,
   output logic                    dm_rvalid_o,
   output logic [DATA_WIDTH-1:0]   dm_rdata_o,
   // downstream memory port
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   // status
   output logic                    err_o
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(MAX_OUT - 1);
   localparam logic [CNT_W-1:0] c_CNT_FULL  = CNT_W'(MAX_OUT);
   localparam logic [STV_W-1:0] c_STV_LIMIT = STV_W'(STARVE_LIMIT);

   // Lock state: FREE lets priority pick the winner, LOCKED holds a
   // presented-but-ungranted request until the memory accepts it.
   typedef enum logic [0:0] {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t             r_state;
   lock_state_t             w_state_nxt;

   // Request captured when the lock engages, so the downstream request stays
   // stable even if the fetch side redirects on a flush.
   logic                    r_lock_if;
   logic                    r_lock_we;
   logic [BE_W-1:0]         r_lock_be;
   logic [ADDR_WIDTH-1:0]   r_lock_addr;
   logic [DATA_WIDTH-1:0]   r_lock_wdata;
   logic                    r_flush_pend;

   logic [STV_W-1:0]        r_starve;

   // Owner FIFO: one entry per granted, unanswered transaction.
   logic                    r_fifo_if   [MAX_OUT];
   logic                    r_fifo_disc [MAX_OUT];
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [CNT_W-1:0]        r_count;
   logic                    r_err;

   logic                    w_locked;
   logic                    w_room;
   logic                    w_req;
   logic                    w_sel_if;
   logic                    w_grant;
   logic                    w_if_quiet;
   logic                    w_push_disc;
   logic                    w_empty;
   logic                    w_pop;
   logic                    w_head_if;
   logic                    w_head_disc;
   logic [PTR_W-1:0]        w_rd_ptr_inc;
   logic [PTR_W-1:0]        w_wr_ptr_inc;

   assign w_locked = (r_state == ST_LOCKED);
   assign w_room   = (r_count < c_CNT_FULL);
   assign w_empty  = (r_count == '0);

   // Request and winner selection; forced quiet while reset is asserted.
   assign w_req    = rst_n && (w_locked || dm_req_i || if_req_i) && w_room;
   assign w_sel_if = w_locked ? r_lock_if
                              : (if_req_i && (!dm_req_i || (r_starve == c_STV_LIMIT)));
   assign w_grant  = w_req && mem_gnt_i;

   // A fetch accepted during or after a flush is wrong-path: hide its grant
   // from the fetch stage and mark its response for silent discard.
   assign w_if_quiet  = flush_i || r_flush_pend;
   assign w_push_disc = w_sel_if && w_if_quiet;

   assign mem_req_o   = w_req;
   assign mem_we_o    = w_locked ? r_lock_we    : (w_sel_if ? 1'b0           : dm_we_i);
   assign mem_be_o    = w_locked ? r_lock_be    : (w_sel_if ? {BE_W{1'b1}}   : dm_be_i);
   assign mem_addr_o  = w_locked ? r_lock_addr  : (w_sel_if ? if_addr_i      : dm_addr_i);
   assign mem_wdata_o = w_locked ? r_lock_wdata : (w_sel_if ? {DATA_WIDTH{1'b0}} : dm_wdata_i);

   assign if_gnt_o = w_grant && w_sel_if && !w_if_quiet;
   assign dm_gnt_o = w_grant && !w_sel_if;

   // Response routing from the FIFO head; a fetch response arriving in the
   // flush cycle itself is already wrong-path and is dropped too.
   assign w_pop       = rst_n && mem_rvalid_i && !w_empty;
   assign w_head_if   = r_fifo_if[r_rd_ptr];
   assign w_head_disc = r_fifo_disc[r_rd_ptr];

   assign if_rvalid_o = w_pop && w_head_if && !w_head_disc && !flush_i;
   assign dm_rvalid_o = w_pop && !w_head_if;
   assign if_rdata_o  = mem_rdata_i;
   assign dm_rdata_o  = mem_rdata_i;
   assign err_o       = r_err;

   assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
   assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;

   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FREE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Lock next-state: engage on an unaccepted request, release on grant.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FREE:   if (w_req && !mem_gnt_i) w_state_nxt = ST_LOCKED;
         ST_LOCKED: if (w_grant)             w_state_nxt = ST_FREE;
         default:                            w_state_nxt = ST_FREE;
      endcase
   end

   // Capture the winning request when the lock engages; track flush-pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_if    <= 1'b0;
         r_lock_we    <= 1'b0;
         r_lock_be    <= '0;
         r_lock_addr  <= '0;
         r_lock_wdata <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (!w_locked && (w_state_nxt == ST_LOCKED)) begin
            r_lock_if    <= w_sel_if;
            r_lock_we    <= mem_we_o;
            r_lock_be    <= mem_be_o;
            r_lock_addr  <= mem_addr_o;
            r_lock_wdata <= mem_wdata_o;
         end
         if (w_grant) begin
            r_flush_pend <= 1'b0;
         end else if (flush_i && w_req && w_sel_if) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   // Starvation counter: counts data grants that bypass a waiting fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (!if_req_i || (w_grant && w_sel_if)) begin
         r_starve <= '0;
      end else if (dm_gnt_o && (r_starve != c_STV_LIMIT)) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   // Owner FIFO: push on grant, pop on response, mark fetches on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_OUT; i++) begin
            r_fifo_if[i]   <= 1'b0;
            r_fifo_disc[i] <= 1'b0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         for (int i = 0; i < MAX_OUT; i++) begin
            if (flush_i && r_fifo_if[i]) r_fifo_disc[i] <= 1'b1;
         end
         if (w_grant) begin
            r_fifo_if[r_wr_ptr]   <= w_sel_if;
            r_fifo_disc[r_wr_ptr] <= w_push_disc;
            r_wr_ptr              <= w_wr_ptr_inc;
         end
         if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
         case ({w_grant, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error on a response with nothing outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (mem_rvalid_i && w_empty) begin
         r_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed scenarios
//                plus a randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 2;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o, if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          dm_req_i, dm_we_i;
   logic [3:0]    dm_be_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic          dm_gnt_o, dm_rvalid_o;
   logic [DW-1:0] dm_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [3:0]    mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i, mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          err_o;

   int n_pass  = 0;
   int n_total = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MO), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
      .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Move to just after the next rising edge (input drive point).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      flush_i = 0; if_req_i = 0; if_addr_i = '0;
      dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; clr_in();
      if_req_i = 1; dm_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
      @(negedge clk);
      n_total++; if ({mem_req_o, if_gnt_o, dm_gnt_o} !== 3'b000) $display("FAIL reset_req_gnt got=%b exp=000", {mem_req_o, if_gnt_o, dm_gnt_o}); else n_pass++;
      n_total++; if ({if_rvalid_o, dm_rvalid_o, err_o} !== 3'b000) $display("FAIL reset_rvalid_err got=%b exp=000", {if_rvalid_o, dm_rvalid_o, err_o}); else n_pass++;
      tick(); clr_in(); rst_n = 1;
      @(negedge clk);
      n_total++; if ({mem_req_o, err_o} !== 2'b00) $display("FAIL reset_idle got=%b exp=00", {mem_req_o, err_o}); else n_pass++;
      tick();
   endtask

   task automatic test_if_fetch();
      if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
      @(negedge clk);
      n_total++; if ({mem_req_o, if_gnt_o, dm_gnt_o} !== 3'b110) $display("FAIL fetch_gnt got=%b exp=110", {mem_req_o, if_gnt_o, dm_gnt_o}); else n_pass++;
      n_total++; if ({mem_addr_o, mem_be_o, mem_we_o} !== {32'h100, 4'hF, 1'b0}) $display("FAIL fetch_fields got=%h/%h/%b exp=100/f/0", mem_addr_o, mem_be_o, mem_we_o); else n_pass++;
      tick(); clr_in(); mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
      @(negedge clk);
      n_total++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b10) $display("FAIL fetch_rvalid got=%b exp=10", {if_rvalid_o, dm_rvalid_o}); else n_pass++;
      n_total++; if (if_rdata_o !== 32'h0050_0093) $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata_o); else n_pass++;
      tick(); clr_in();
   endtask

   task automatic test_starvation();
      bit exp_if, exp_rv_if;
      if_req_i = 1; if_addr_i = 32'h400; dm_req_i = 1; dm_addr_i = 32'h8000; dm_be_i = 4'h3;
      mem_gnt_i = 1;
      for (int i = 0; i <= 10; i++) begin
         if (i == 10) begin if_req_i = 0; dm_req_i = 0; end
         mem_rvalid_i = (i > 0); mem_rdata_i = 32'hA000 + i;
         exp_if    = (i % 5 == 4) && (i < 10);
         exp_rv_if = (i > 0) && ((i - 1) % 5 == 4);
         @(negedge clk);
         n_total++; if ({if_gnt_o, dm_gnt_o} !== {exp_if, !exp_if && (i < 10)}) $display("FAIL starve_gnt cyc=%0d got=%b%b exp=%b%b", i, if_gnt_o, dm_gnt_o, exp_if, !exp_if && (i < 10)); else n_pass++;
         if (i > 0) begin
            n_total++; if ({if_rvalid_o, dm_rvalid_o} !== {exp_rv_if, !exp_rv_if}) $display("FAIL starve_route cyc=%0d got=%b%b exp=%b%b", i, if_rvalid_o, dm_rvalid_o, exp_rv_if, !exp_rv_if); else n_pass++;
         end
         tick();
      end
      clr_in();
   endtask

   task automatic test_lock();
      for (int i = 0; i < 7; i++) begin
         clr_in();
         if (i <= 3) begin if_req_i = 1; if_addr_i = 32'h300; end
         if (i >= 1 && i <= 4) begin dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'h1; dm_addr_i = 32'h4000; dm_wdata_i = 32'hDEAD; end
         mem_gnt_i    = (i == 3 || i == 4);
         mem_rvalid_i = (i >= 5); mem_rdata_i = 32'h5500 + i;
         @(negedge clk);
         if (i <= 3) begin
            n_total++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) $display("FAIL lock_hold cyc=%0d got=%b/%h exp=1/300", i, mem_req_o, mem_addr_o); else n_pass++;
            n_total++; if ({if_gnt_o, dm_gnt_o} !== {(i == 3), 1'b0}) $display("FAIL lock_gnt cyc=%0d got=%b%b exp=%b0", i, if_gnt_o, dm_gnt_o, (i == 3)); else n_pass++;
         end else if (i == 4) begin
            n_total++; if ({dm_gnt_o, mem_addr_o, mem_we_o, mem_wdata_o} !== {1'b1, 32'h4000, 1'b1, 32'hDEAD}) $display("FAIL lock_dm_after got=%b/%h/%b/%h exp=1/4000/1/dead", dm_gnt_o, mem_addr_o, mem_we_o, mem_wdata_o); else n_pass++;
         end else begin
            n_total++; if ({if_rvalid_o, dm_rvalid_o} !== {(i == 5), (i == 6)}) $display("FAIL lock_route cyc=%0d got=%b%b exp=%b%b", i, if_rvalid_o, dm_rvalid_o, (i == 5), (i == 6)); else n_pass++;
         end
         tick();
      end
      clr_in();
   endtask

   task automatic test_max_out();
      for (int i = 0; i < 7; i++) begin
         clr_in();
         if (i <= 4) begin dm_req_i = 1; dm_be_i = 4'hF; dm_addr_i = (i <= 1) ? 32'h1000 + 4 * i : 32'h1008; end
         mem_gnt_i    = (i != 3);
         mem_rvalid_i = (i >= 3 && i <= 5); mem_rdata_i = 32'hC0 + i;
         @(negedge clk);
         n_total++; if (mem_req_o !== (i != 2 && i != 3 && i <= 4)) $display("FAIL maxout_req cyc=%0d got=%b exp=%b", i, mem_req_o, (i != 2 && i != 3 && i <= 4)); else n_pass++;
         n_total++; if (dm_rvalid_o !== (i >= 3 && i <= 5)) $display("FAIL maxout_rvalid cyc=%0d got=%b exp=%b", i, dm_rvalid_o, (i >= 3 && i <= 5)); else n_pass++;
         if (i == 4) begin
            n_total++; if ({dm_gnt_o, mem_addr_o, dm_rdata_o} !== {1'b1, 32'h1008, 32'hC4}) $display("FAIL maxout_swap got=%b/%h/%h exp=1/1008/c4", dm_gnt_o, mem_addr_o, dm_rdata_o); else n_pass++;
         end
         tick();
      end
      clr_in();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 12; i++) begin
         clr_in();
         case (i)
            0, 1: begin if_req_i = 1; if_addr_i = 32'h10 + 4 * i; mem_gnt_i = 1; end
            2:    flush_i = 1;
            3, 4: begin mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0 + i; end
            5:    begin if_req_i = 1; if_addr_i = 32'h200; mem_gnt_i = 1; end
            6:    begin mem_rvalid_i = 1; mem_rdata_i = 32'h13; end
            7:    begin if_req_i = 1; if_addr_i = 32'h220; end
            8:    flush_i = 1;
            9:    mem_gnt_i = 1;
            10:   begin mem_rvalid_i = 1; mem_rdata_i = 32'hBAD9; end
            default: ;
         endcase
         @(negedge clk);
         n_total++; if (if_rvalid_o !== (i == 6)) $display("FAIL flush_rvalid cyc=%0d got=%b exp=%b", i, if_rvalid_o, (i == 6)); else n_pass++;
         if (i == 5) begin
            n_total++; if ({mem_req_o, if_gnt_o} !== 2'b11) $display("FAIL flush_refetch got=%b exp=11", {mem_req_o, if_gnt_o}); else n_pass++;
         end
         if (i == 6) begin
            n_total++; if (if_rdata_o !== 32'h13) $display("FAIL flush_refetch_data got=%h exp=13", if_rdata_o); else n_pass++;
         end
         if (i == 8 || i == 9) begin
            n_total++; if ({mem_req_o, mem_addr_o, if_gnt_o} !== {1'b1, 32'h220, 1'b0}) $display("FAIL flush_locked cyc=%0d got=%b/%h/%b exp=1/220/0", i, mem_req_o, mem_addr_o, if_gnt_o); else n_pass++;
         end
         if (i == 11) begin
            n_total++; if ({mem_req_o, err_o} !== 2'b00) $display("FAIL flush_end got=%b exp=00", {mem_req_o, err_o}); else n_pass++;
         end
         tick();
      end
      clr_in();
   endtask

   task automatic test_err();
      mem_rvalid_i = 1; mem_rdata_i = 32'h77;
      @(negedge clk);
      n_total++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) $display("FAIL err_drop got=%b exp=00", {if_rvalid_o, dm_rvalid_o}); else n_pass++;
      tick(); clr_in();
      @(negedge clk);
      n_total++; if (err_o !== 1'b1) $display("FAIL err_set got=%b exp=1", err_o); else n_pass++;
      repeat (3) tick();
      @(negedge clk);
      n_total++; if (err_o !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err_o); else n_pass++;
      rst_n = 0; #1;
      n_total++; if (err_o !== 1'b0) $display("FAIL err_clear got=%b exp=0", err_o); else n_pass++;
      tick(); rst_n = 1; tick();
   endtask

   // Randomized traffic against a transaction-level model: a queue of
   // outstanding {owner, discard} entries plus the arbitration rules.
   task automatic test_random();
      bit q_if[$];
      bit q_dc[$];
      int st = 0;
      bit lk = 0, lk_if = 0, lk_we = 0, fp = 0;
      logic [AW-1:0] lk_addr = '0;
      logic [DW-1:0] lk_wd = '0;
      logic [3:0]    lk_be = '0;
      bit p_ifg = 0, p_dmg = 0;
      bit e_req, e_sel_if, e_grant, e_ifg, e_dmg, e_pop, e_ifrv, e_dmrv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic [3:0]    e_be;
      bit e_we;
      int errs_before;
      clr_in();
      rst_n = 0; tick(); rst_n = 1; tick();
      errs_before = n_total - n_pass;
      for (int c = 0; c < 3000; c++) begin
         flush_i = ($urandom_range(0, 19) == 0);
         if (!if_req_i || p_ifg || flush_i) begin
            if_req_i  = ($urandom_range(0, 9) < 6);
            if_addr_i = {$urandom_range(0, 65535), 2'b00};
         end
         if (!dm_req_i || p_dmg) begin
            dm_req_i   = ($urandom_range(0, 9) < 5);
            dm_we_i    = $urandom_range(0, 1);
            dm_be_i    = $urandom_range(0, 15);
            dm_addr_i  = $urandom;
            dm_wdata_i = $urandom;
         end
         mem_gnt_i    = ($urandom_range(0, 9) < 7);
         mem_rvalid_i = (q_if.size() > 0) && ($urandom_range(0, 9) < 6);
         mem_rdata_i  = $urandom;
         @(negedge clk);
         // expected behaviour for this cycle
         e_req    = (lk || dm_req_i || if_req_i) && (q_if.size() < MO);
         e_sel_if = lk ? lk_if : (if_req_i && (!dm_req_i || st == SL));
         e_addr   = lk ? lk_addr : (e_sel_if ? if_addr_i : dm_addr_i);
         e_we     = lk ? lk_we : (e_sel_if ? 1'b0 : dm_we_i);
         e_be     = lk ? lk_be : (e_sel_if ? 4'hF : dm_be_i);
         e_wd     = lk ? lk_wd : (e_sel_if ? '0 : dm_wdata_i);
         e_grant  = e_req && mem_gnt_i;
         e_ifg    = e_grant && e_sel_if && !flush_i && !fp;
         e_dmg    = e_grant && !e_sel_if;
         e_pop    = mem_rvalid_i && (q_if.size() > 0);
         e_ifrv   = e_pop && q_if[0] && !q_dc[0] && !flush_i;
         e_dmrv   = e_pop && !q_if[0];
         n_total++; if ({mem_req_o, if_gnt_o, dm_gnt_o} !== {e_req, e_ifg, e_dmg}) $display("FAIL rnd_req_gnt cyc=%0d got=%b%b%b exp=%b%b%b", c, mem_req_o, if_gnt_o, dm_gnt_o, e_req, e_ifg, e_dmg); else n_pass++;
         n_total++; if ({if_rvalid_o, dm_rvalid_o, err_o} !== {e_ifrv, e_dmrv, 1'b0}) $display("FAIL rnd_rvalid cyc=%0d got=%b%b%b exp=%b%b0", c, if_rvalid_o, dm_rvalid_o, err_o, e_ifrv, e_dmrv); else n_pass++;
         if (e_req) begin
            n_total++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {e_addr, e_we, e_be, e_wd}) $display("FAIL rnd_fields cyc=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, e_addr, e_we, e_be, e_wd); else n_pass++;
         end
         if (e_ifrv || e_dmrv) begin
            n_total++; if ((e_ifrv ? if_rdata_o : dm_rdata_o) !== mem_rdata_i) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, (e_ifrv ? if_rdata_o : dm_rdata_o), mem_rdata_i); else n_pass++;
         end
         // advance the model
         if (flush_i) foreach (q_if[k]) if (q_if[k]) q_dc[k] = 1;
         if (e_pop) begin void'(q_if.pop_front()); void'(q_dc.pop_front()); end
         if (e_grant) begin q_if.push_back(e_sel_if); q_dc.push_back(e_sel_if && (flush_i || fp)); end
         if (!if_req_i || (e_grant && e_sel_if)) st = 0;
         else if (e_dmg && st < SL) st++;
         if (e_grant) fp = 0;
         else if (flush_i && e_req && e_sel_if) fp = 1;
         if (!lk && e_req && !mem_gnt_i) begin
            lk = 1; lk_if = e_sel_if; lk_addr = e_addr; lk_we = e_we; lk_be = e_be; lk_wd = e_wd;
         end else if (e_grant) lk = 0;
         p_ifg = e_ifg; p_dmg = e_dmg;
         @(posedge clk); #1;
      end
      if (n_total - n_pass != errs_before) $display("random run saw %0d discrepancies", n_total - n_pass - errs_before);
      clr_in();
   endtask

   initial begin
      clr_in();
      rst_n = 0;
      #1;
      test_reset();
      test_if_fetch();
      test_starvation();
      test_lock();
      test_max_out();
      test_flush();
      test_err();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
